// File: rtl/drive_volume_arbiter_if.sv
// rtl/drive_volume_arbiter_if.sv - drive-side and volume-side signal bundle for drive_volume_arbiter
interface drive_volume_arbiter_if #(
    parameter int NUM_DRIVES = 4
);
    logic [NUM_DRIVES-1:0]    drv_active;
    logic [32*NUM_DRIVES-1:0] drv_lba;
    logic [6*NUM_DRIVES-1:0]  drv_blk_cnt;
    logic [NUM_DRIVES-1:0]    drv_rd;
    logic [NUM_DRIVES-1:0]    drv_wr;
    logic [NUM_DRIVES-1:0]    drv_ack;
    logic                     drv_ready;
    logic                     drv_mounted;
    logic                     drv_readonly;
    logic [31:0]              drv_size;
    logic                     vol_ready;
    logic                     vol_mounted;
    logic                     vol_readonly;
    logic [31:0]              vol_size;
    logic                     vol_active;
    logic [31:0]              vol_lba;
    logic [5:0]               vol_blk_cnt;
    logic                     vol_rd;
    logic                     vol_wr;
    logic                     vol_ack;
    logic                     busy;
    logic [2:0]               grant_id;

    modport slave (
        input  drv_active, drv_lba, drv_blk_cnt, drv_rd, drv_wr,
        input  vol_ready, vol_mounted, vol_readonly, vol_size, vol_ack,
        output drv_ack, drv_ready, drv_mounted, drv_readonly, drv_size,
        output vol_active, vol_lba, vol_blk_cnt, vol_rd, vol_wr, busy, grant_id
    );

    modport master (
        output drv_active, drv_lba, drv_blk_cnt, drv_rd, drv_wr,
        output vol_ready, vol_mounted, vol_readonly, vol_size, vol_ack,
        input  drv_ack, drv_ready, drv_mounted, drv_readonly, drv_size,
        input  vol_active, vol_lba, vol_blk_cnt, vol_rd, vol_wr, busy, grant_id
    );
endinterface

// File: rtl/drive_volume_arbiter.sv
// rtl/drive_volume_arbiter.sv - round-robin sharing of one block volume between drive engines
module drive_volume_arbiter #(
    parameter int NUM_DRIVES  = 4,
    parameter int ACK_TIMEOUT = 2**20
) (
    input  logic                    clk,
    input  logic                    reset,
    drive_volume_arbiter_if.slave   bus
);
    localparam int TW = ($clog2(ACK_TIMEOUT) + 1 > 21) ? $clog2(ACK_TIMEOUT) + 1 : 21;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_REJECT, S_DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             rr_ptr;
    logic [2:0]             grant_q;
    logic [31:0]            lba_q;
    logic [5:0]             cnt_q;
    logic                   op_wr;
    logic [TW-1:0]          tmo_cnt;
    logic [NUM_DRIVES-1:0]  ack_q;

    logic                   req_found;
    logic [2:0]             req_idx;
    logic [3:0]             cand;
    logic [31:0]            sel_lba;
    logic [5:0]             sel_cnt;
    logic                   sel_rd;
    logic                   reject_now;
    logic                   tmo_hit;

    function automatic logic [NUM_DRIVES-1:0] onehot(input logic [2:0] idx);
        onehot = '0;
        for (int j = 0; j < NUM_DRIVES; j++) begin
            if (idx == 3'(j)) onehot[j] = 1'b1;
        end
    endfunction

    assign bus.drv_ready    = bus.vol_ready;
    assign bus.drv_mounted  = bus.vol_mounted;
    assign bus.drv_readonly = bus.vol_readonly;
    assign bus.drv_size     = bus.vol_size;
    assign bus.vol_active   = |bus.drv_active;

    // Request strobes come straight from the state so reset kills them without a clock edge.
    assign bus.vol_rd      = (state == S_REQ) && !op_wr;
    assign bus.vol_wr      = (state == S_REQ) && op_wr;
    assign bus.busy        = (state != S_IDLE);
    assign bus.drv_ack     = ack_q;
    assign bus.vol_lba     = lba_q;
    assign bus.vol_blk_cnt = cnt_q;
    assign bus.grant_id    = grant_q;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Scan candidates rr_ptr, rr_ptr+1, ... with wrap; first requesting drive wins.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_DRIVES; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_DRIVES)) cand = cand - 4'(NUM_DRIVES);
            for (int j = 0; j < NUM_DRIVES; j++) begin
                if (!req_found && cand == 4'(j) && (bus.drv_rd[j] || bus.drv_wr[j])) begin
                    req_found = 1'b1;
                    req_idx   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        sel_lba = '0;
        sel_cnt = '0;
        sel_rd  = 1'b0;
        for (int j = 0; j < NUM_DRIVES; j++) begin
            if (req_idx == 3'(j)) begin
                sel_lba = bus.drv_lba[32*j +: 32];
                sel_cnt = bus.drv_blk_cnt[6*j +: 6];
                sel_rd  = bus.drv_rd[j];
            end
        end
        reject_now = (!sel_rd && bus.vol_readonly) || !bus.vol_mounted || !bus.vol_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (req_found) state_next = reject_now ? S_REJECT : S_REQ;
            S_REQ: begin
                if (bus.vol_ack)  state_next = S_XFER;
                else if (tmo_hit) state_next = S_REJECT;
            end
            S_XFER:   if (!bus.vol_ack) state_next = S_DONE;
            S_REJECT: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            lba_q   <= '0;
            cnt_q   <= '0;
            op_wr   <= 1'b0;
            tmo_cnt <= '0;
            ack_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_found) begin
                    grant_q <= req_idx;
                    lba_q   <= sel_lba;
                    cnt_q   <= sel_cnt;
                    op_wr   <= !sel_rd;
                    tmo_cnt <= '0;
                    if (reject_now) ack_q <= onehot(req_idx);
                end
                S_REQ: begin
                    if (bus.vol_ack || tmo_hit) ack_q   <= onehot(grant_q);
                    else                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_XFER:   ack_q <= {NUM_DRIVES{bus.vol_ack}} & onehot(grant_q);
                S_REJECT: ack_q <= '0;
                S_DONE:   rr_ptr <= (grant_q == 3'(NUM_DRIVES - 1)) ? 3'd0 : grant_q + 3'd1;
                default:  ack_q <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_drive_volume_arbiter.sv
// tb/tb_drive_volume_arbiter.sv - randomized and directed checks of drive_volume_arbiter against a transaction model
`timescale 1ns/1ps
module tb_drive_volume_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    drive_volume_arbiter_if #(.NUM_DRIVES(N)) bus ();
    drive_volume_arbiter #(.NUM_DRIVES(N), .ACK_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int w);
        oh = N'(1) << w;
    endfunction

    // stimulus controls (main process writes, helper processes read)
    logic          rand_en = 0, rand_status = 0, stuck = 0, post_en = 0, cmp_en = 0;
    logic [N-1:0]  hold = '0;
    logic          st_ready = 1, st_mounted = 1, st_readonly = 0;
    int            fix_d = -1, fix_l = -1;
    int            dir_seq [N];
    int            dir_op  [N];
    logic [31:0]   dir_lba [N];
    logic [5:0]    dir_cnt [N];
    logic [31:0]   post_lba [N];

    // drive-process state
    logic [N-1:0]  pend = '0;
    int            dir_seen [N];

    task automatic issue(input int i, input int op, input logic [31:0] lba, input logic [5:0] cnt);
        dir_op[i] = op; dir_lba[i] = lba; dir_cnt[i] = cnt; dir_seq[i] = dir_seq[i] + 1;
    endtask

    // drive clients and volume status
    initial begin
        int op;
        bus.drv_rd = '0; bus.drv_wr = '0; bus.drv_lba = '0; bus.drv_blk_cnt = '0; bus.drv_active = '0;
        bus.vol_ready = 1; bus.vol_mounted = 1; bus.vol_readonly = 0; bus.vol_size = 32'h0001_2345;
        for (int i = 0; i < N; i++) dir_seen[i] = 0;
        forever begin
            @(posedge clk); #1;
            bus.drv_active = N'($urandom);
            if (rand_status) begin
                bus.vol_ready    = ($urandom_range(0, 9) != 0);
                bus.vol_mounted  = ($urandom_range(0, 11) != 0);
                bus.vol_readonly = ($urandom_range(0, 4) == 0);
                bus.vol_size     = $urandom;
            end else begin
                bus.vol_ready = st_ready; bus.vol_mounted = st_mounted; bus.vol_readonly = st_readonly;
            end
            for (int i = 0; i < N; i++) begin
                if (reset) begin
                    pend[i] = 0; bus.drv_rd[i] = 0; bus.drv_wr[i] = 0; dir_seen[i] = dir_seq[i];
                end else if (pend[i]) begin
                    if (bus.drv_ack[i]) begin
                        bus.drv_rd[i] = 0; bus.drv_wr[i] = 0; pend[i] = 0;
                        if (post_en) bus.drv_lba[32*i +: 32] = post_lba[i];
                        else if (rand_en) bus.drv_lba[32*i +: 32] = $urandom;
                    end
                end else if (!bus.drv_ack[i]) begin
                    if (dir_seen[i] != dir_seq[i]) begin
                        dir_seen[i] = dir_seq[i];
                        bus.drv_rd[i] = (dir_op[i] != 1); bus.drv_wr[i] = (dir_op[i] != 0);
                        bus.drv_lba[32*i +: 32] = dir_lba[i]; bus.drv_blk_cnt[6*i +: 6] = dir_cnt[i];
                        pend[i] = 1;
                    end else if (hold[i] || (rand_en && $urandom_range(0, 3) == 0)) begin
                        op = hold[i] ? 0 : $urandom_range(0, 2);
                        bus.drv_rd[i] = (op != 1); bus.drv_wr[i] = (op != 0);
                        bus.drv_lba[32*i +: 32] = $urandom; bus.drv_blk_cnt[6*i +: 6] = 6'($urandom);
                        pend[i] = 1;
                    end
                end
            end
        end
    end

    // volume responder
    initial begin
        int d, l;
        bus.vol_ack = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset && !stuck && (bus.vol_rd || bus.vol_wr)) begin
                d = (fix_d >= 0) ? fix_d : $urandom_range(0, 4);
                l = (fix_l >= 0) ? fix_l : $urandom_range(1, 4);
                repeat (d) begin @(posedge clk); #1; end
                bus.vol_ack = 1;
                repeat (l) begin @(posedge clk); #1; end
                bus.vol_ack = 0;
            end
        end
    end

    // transaction model: what the outputs must be, derived from the arbitration rules
    logic [N-1:0] exp_ack = '0;
    logic         exp_busy = 0, exp_rd = 0, exp_wr = 0;
    logic [2:0]   exp_grant = '0;
    logic [31:0]  exp_lba = '0;
    logic [5:0]   exp_cnt = '0;

    initial begin
        int w, j, m_rr, n;
        logic wr_op, acked, rejected;
        logic [N-1:0] v;
        m_rr = 0;
        wait (reset == 0);
        forever begin
            @(posedge clk);
            v = bus.drv_rd | bus.drv_wr;
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (w < 0 && v[j]) w = j;
            end
            if (w >= 0) begin
                wr_op     = !bus.drv_rd[w];
                exp_grant = 3'(w);
                exp_lba   = bus.drv_lba[32*w +: 32];
                exp_cnt   = bus.drv_blk_cnt[6*w +: 6];
                exp_busy  = 1;
                rejected  = (wr_op && bus.vol_readonly) || !bus.vol_mounted || !bus.vol_ready;
                if (rejected) begin
                    exp_ack = oh(w);
                    @(posedge clk); exp_ack = '0;
                end else begin
                    exp_rd = !wr_op; exp_wr = wr_op;
                    n = 0; acked = 0;
                    while (!acked && n < TMO) begin
                        @(posedge clk);
                        if (bus.vol_ack) acked = 1; else n++;
                    end
                    exp_rd = 0; exp_wr = 0; exp_ack = oh(w);
                    if (acked) begin
                        do begin
                            @(posedge clk);
                            exp_ack = bus.vol_ack ? oh(w) : '0;
                        end while (bus.vol_ack);
                    end else begin
                        @(posedge clk); exp_ack = '0;
                    end
                end
                @(posedge clk);
                exp_busy = 0;
                m_rr = (w + 1) % N;
            end
        end
    end

    // per-cycle comparison and event monitor
    int   cnt_rd = 0, cnt_wr = 0;
    int   cnt_ack [N];
    int   glog [$];
    logic prev_busy = 0;
    initial for (int i = 0; i < N; i++) cnt_ack[i] = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", bus.busy, exp_busy);
            check("grant_id", bus.grant_id, exp_grant);
            check("vol_rd", bus.vol_rd, exp_rd);
            check("vol_wr", bus.vol_wr, exp_wr);
            check("drv_ack", bus.drv_ack, exp_ack);
            check("vol_lba", bus.vol_lba, exp_lba);
            check("vol_blk_cnt", bus.vol_blk_cnt, exp_cnt);
        end
        check("vol_active", bus.vol_active, |bus.drv_active);
        check("drv_status", {bus.drv_ready, bus.drv_mounted, bus.drv_readonly, bus.drv_size},
              {bus.vol_ready, bus.vol_mounted, bus.vol_readonly, bus.vol_size});
        cnt_rd += int'(bus.vol_rd);
        cnt_wr += int'(bus.vol_wr);
        for (int i = 0; i < N; i++) cnt_ack[i] += int'(bus.drv_ack[i]);
        if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
        prev_busy = bus.busy;
    end

    function automatic logic dir_busy();
        dir_busy = 0;
        for (int i = 0; i < N; i++) if (dir_seq[i] != dir_seen[i]) dir_busy = 1;
    endfunction

    task automatic wait_idle(input string name, input int max);
        int c;
        c = 0;
        @(negedge clk);
        while ((bus.busy || pend != '0 || dir_busy()) && c < max) begin @(negedge clk); c++; end
        checks++;
        if (c >= max) begin
            failures++;
            $display("FAIL %s idle-wait actual=busy required=idle within %0d cycles", name, max);
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int b_rd, b_wr, b_ack, b_g, c;
        for (int i = 0; i < N; i++) begin dir_seq[i] = 0; dir_op[i] = 0; dir_lba[i] = '0; dir_cnt[i] = '0; post_lba[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_vol_rd", bus.vol_rd, 1'b0);
        check("rst_vol_wr", bus.vol_wr, 1'b0);
        check("rst_drv_ack", bus.drv_ack, '0);
        check("rst_grant", bus.grant_id, 3'd0);
        check("rst_vol_lba", bus.vol_lba, 32'd0);
        check("rst_blk_cnt", bus.vol_blk_cnt, 6'd0);
        @(posedge clk); #1;
        reset = 0;
        cmp_en = 1;

        // fairness: all four hold read requests continuously
        @(negedge clk);
        b_g = glog.size();
        hold = 4'b1111;
        c = 0;
        while (glog.size() < b_g + 5 && c < 400) begin @(negedge clk); c++; end
        hold = '0;
        check("fair_wait", (glog.size() >= b_g + 5), 1'b1);
        if (glog.size() >= b_g + 5) begin
            check("fair_g0", glog[b_g],     0);
            check("fair_g1", glog[b_g + 1], 1);
            check("fair_g2", glog[b_g + 2], 2);
            check("fair_g3", glog[b_g + 3], 3);
            check("fair_g4", glog[b_g + 4], 0);
        end
        wait_idle("fair", 400);

        // single read on drive 1, ack 3 cycles after request, 2 cycles long
        fix_d = 3; fix_l = 2;
        @(negedge clk);
        b_rd = cnt_rd; b_wr = cnt_wr; b_ack = cnt_ack[1]; b_g = glog.size();
        issue(1, 0, 32'h100, 6'd0);
        wait_idle("read1", 100);
        check("read1_rd_cycles", cnt_rd - b_rd, 4);
        check("read1_wr_cycles", cnt_wr - b_wr, 0);
        check("read1_ack_cycles", cnt_ack[1] - b_ack, 2);
        check("read1_grant", (glog.size() > b_g) ? glog[b_g] : -1, 1);
        check("read1_lba", bus.vol_lba, 32'h100);

        // write to a read-only volume is rejected with a single ack pulse
        st_readonly = 1;
        @(negedge clk);
        b_wr = cnt_wr; b_ack = cnt_ack[2];
        issue(2, 1, 32'h777, 6'd5);
        wait_idle("ro_write", 100);
        check("ro_wr_cycles", cnt_wr - b_wr, 0);
        check("ro_ack_cycles", cnt_ack[2] - b_ack, 1);
        check("ro_grant", bus.grant_id, 3'd2);
        st_readonly = 0;

        // ack never arrives: request held for exactly TMO cycles
        stuck = 1;
        @(negedge clk);
        b_rd = cnt_rd; b_ack = cnt_ack[3];
        issue(3, 0, 32'h3333, 6'd1);
        wait_idle("timeout", 100);
        check("tmo_rd_cycles", cnt_rd - b_rd, 16);
        check("tmo_ack_cycles", cnt_ack[3] - b_ack, 1);
        stuck = 0;

        // latched address survives the drive changing its lba mid-transfer
        fix_d = 1; fix_l = 4; post_lba[0] = 32'h5; post_en = 1;
        @(negedge clk);
        issue(0, 0, 32'h200, 6'd7);
        wait_idle("latch", 100);
        check("latch_lba", bus.vol_lba, 32'h200);
        check("latch_cnt", bus.vol_blk_cnt, 6'd7);
        post_en = 0;

        // randomized traffic with fluctuating status and stuck-ack windows
        fix_d = -1; fix_l = -1; rand_status = 1; rand_en = 1;
        for (int blk = 0; blk < 15; blk++) begin
            repeat (160) @(negedge clk);
            stuck = 1;
            repeat (40) @(negedge clk);
            stuck = 0;
        end
        rand_en = 0;
        wait_idle("random_drain", 400);
        rand_status = 0;
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of a transfer
        fix_d = 0; fix_l = 4;
        @(negedge clk);
        issue(2, 0, 32'h4242, 6'd3);
        c = 0;
        @(negedge clk);
        while (!bus.drv_ack[2] && c < 40) begin @(negedge clk); c++; end
        check("xfer_reached", bus.drv_ack[2], 1'b1);
        cmp_en = 0;
        #1 reset = 1;
        #1;
        check("arst_vol_rd", bus.vol_rd, 1'b0);
        check("arst_vol_wr", bus.vol_wr, 1'b0);
        check("arst_drv_ack", bus.drv_ack, '0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_grant", bus.grant_id, 3'd0);
        repeat (6) @(negedge clk);
        reset = 0;
        @(negedge clk);
        issue(3, 0, 32'h99, 6'd0);
        issue(0, 0, 32'h88, 6'd0);
        c = 0;
        @(negedge clk);
        while (!bus.busy && c < 40) begin @(negedge clk); c++; end
        check("post_rst_grant", bus.grant_id, 3'd0);
        check("post_rst_lba", bus.vol_lba, 32'h88);
        wait_idle("post_rst", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
